// File: rtl/rf_writeback_queue_pkg.sv
// Shared defaults and the writeback entry type for the register-file writeback queue.
package rf_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int BUS_W_DEF  = 32;
   localparam int DEPTH_DEF  = 4;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [BUS_W_DEF-1:0]  data;
   } wb_entry_t;

endpackage

// File: rtl/rf_wbq_fifo.sv
// Circular buffer for pending writebacks. It also exposes an age-ordered view of every slot
// (oldest first) with a valid mask, so the parent can search the queue for bypass hits.
module rf_wbq_fifo
   import rf_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = wb_entry_t
)(
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  entry_t                       entry_i,
   input  logic                         pop_i,
   output entry_t                       head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output entry_t                       entries_o [DEPTH],
   output logic [DEPTH-1:0]             valid_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   entry_t        mem_q [DEPTH];
   logic          do_push_s, do_pop_s;

   // Full/empty guards make the buffer safe even if the parent misbehaves.
   assign do_push_s = push_i && (count_q < CNT_MAX);
   assign do_pop_s  = pop_i && (count_q != {CW{1'b0}});

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and storage registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= entry_i;
         end
      end
   end

   // Age-ordered view: index 0 is the head, higher indices are younger.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries_o[i] = mem_q[rd_ptr_q + PW'(i)];
         valid_o[i]   = (CW'(i) < count_q);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: handshake in, one registered write per cycle out, optional
// read-port bypass compiled in when RF_WB_BYPASS_EN is defined (tied off otherwise).
module rf_writeback_queue
   import rf_pkg::*;
#(
   parameter int ADDR  = ADDR_W_DEF,
   parameter int BUS_W = BUS_W_DEF,
   parameter int DEPTH = DEPTH_DEF
)(
   input  logic                        reloj_cucu,
   input  logic                        reset,
   input  logic                        wb_valid,
   output logic                        wb_ready,
   input  logic [ADDR-1:0]             wb_addr,
   input  logic [BUS_W-1:0]            wb_data,
   output logic                        r_write,
   output logic [ADDR-1:0]             rd_addr,
   output logic [BUS_W-1:0]            rd_w_data,
   input  logic [ADDR-1:0]             rs_addr,
   input  logic [ADDR-1:0]             rt_addr,
   output logic                        rs_hit,
   output logic                        rt_hit,
   output logic [BUS_W-1:0]            rs_fwd_data,
   output logic [BUS_W-1:0]            rt_fwd_data,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR-1:0]  addr;
      logic [BUS_W-1:0] data;
   } entry_t;

   entry_t           wb_entry_s;
   entry_t           head_s;
   entry_t           entries_s [DEPTH];
   logic [DEPTH-1:0] valid_s;
   logic [CW-1:0]    count_s;
   logic             push_s, pop_s;

   logic             r_write_q, r_write_d;
   logic [ADDR-1:0]  rd_addr_q, rd_addr_d;
   logic [BUS_W-1:0] rd_w_data_q, rd_w_data_d;

   assign wb_entry_s = '{addr: wb_addr, data: wb_data};
   assign wb_ready   = (count_s < CW'(DEPTH));
   // Writes to register 0 complete the handshake but never occupy a slot.
   assign push_s     = wb_valid && wb_ready && (wb_addr != {ADDR{1'b0}});
   assign pop_s      = (count_s != {CW{1'b0}});

   rf_wbq_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i     (reloj_cucu),
      .rst_i     (reset),
      .push_i    (push_s),
      .entry_i   (wb_entry_s),
      .pop_i     (pop_s),
      .head_o    (head_s),
      .count_o   (count_s),
      .entries_o (entries_s),
      .valid_o   (valid_s)
   );

   // Drain stage: load the head when something is queued, otherwise hold the write port.
   always_comb begin
      r_write_d   = pop_s;
      rd_addr_d   = rd_addr_q;
      rd_w_data_d = rd_w_data_q;
      if (pop_s) begin
         rd_addr_d   = head_s.addr;
         rd_w_data_d = head_s.data;
      end else begin
         rd_addr_d   = rd_addr_q;
         rd_w_data_d = rd_w_data_q;
      end
   end

   // Registered register-file write port.
   always_ff @(posedge reloj_cucu or posedge reset) begin
      if (reset) begin
         r_write_q   <= 1'b0;
         rd_addr_q   <= {ADDR{1'b0}};
         rd_w_data_q <= {BUS_W{1'b0}};
      end else begin
         r_write_q   <= r_write_d;
         rd_addr_q   <= rd_addr_d;
         rd_w_data_q <= rd_w_data_d;
      end
   end

   assign r_write   = r_write_q;
   assign rd_addr   = rd_addr_q;
   assign rd_w_data = rd_w_data_q;
   assign count     = count_s;

`ifdef RF_WB_BYPASS_EN
   // Write port is the oldest candidate; walking the queue head-to-tail lets the youngest win.
   function automatic logic [BUS_W:0] bypass_lookup(input logic [ADDR-1:0] a);
      logic             hit;
      logic [BUS_W-1:0] data;
      hit  = 1'b0;
      data = {BUS_W{1'b0}};
      if (a != {ADDR{1'b0}}) begin
         if (r_write_q && (rd_addr_q == a)) begin
            hit  = 1'b1;
            data = rd_w_data_q;
         end else begin
            hit  = 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i] && (entries_s[i].addr == a)) begin
               hit  = 1'b1;
               data = entries_s[i].data;
            end else begin
               hit  = hit;
            end
         end
      end else begin
         hit = 1'b0;
      end
      return {hit, data};
   endfunction

   // Zero-latency bypass for both read ports.
   always_comb begin
      {rs_hit, rs_fwd_data} = bypass_lookup(rs_addr);
      {rt_hit, rt_fwd_data} = bypass_lookup(rt_addr);
   end
`else
   logic unused_bypass_s;

   assign rs_hit      = 1'b0;
   assign rt_hit      = 1'b0;
   assign rs_fwd_data = {BUS_W{1'b0}};
   assign rt_fwd_data = {BUS_W{1'b0}};

   // Sink for the per-entry view and read addresses that only the bypass consumes.
   always_comb begin
      unused_bypass_s = ^{rs_addr, rt_addr, valid_s};
      for (int i = 0; i < DEPTH; i++) begin
         unused_bypass_s = unused_bypass_s ^ (^entries_s[i]);
      end
   end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Scoreboard bench for rf_writeback_queue; accepted writes are queued as expectations and a
// negedge monitor checks every register-file write against them.
module tb_rf_writeback_queue;

   localparam int ADDR  = 5;
   localparam int BUS_W = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             reloj_cucu = 1'b0;
   logic             reset;
   logic             wb_valid;
   logic             wb_ready;
   logic [ADDR-1:0]  wb_addr;
   logic [BUS_W-1:0] wb_data;
   logic             r_write;
   logic [ADDR-1:0]  rd_addr;
   logic [BUS_W-1:0] rd_w_data;
   logic [ADDR-1:0]  rs_addr, rt_addr;
   logic             rs_hit, rt_hit;
   logic [BUS_W-1:0] rs_fwd_data, rt_fwd_data;
   logic [CW-1:0]    count;

   typedef struct packed {
      logic [ADDR-1:0]  addr;
      logic [BUS_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   rf_writeback_queue #(.ADDR(ADDR), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
      .reloj_cucu  (reloj_cucu),
      .reset       (reset),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .r_write     (r_write),
      .rd_addr     (rd_addr),
      .rd_w_data   (rd_w_data),
      .rs_addr     (rs_addr),
      .rt_addr     (rt_addr),
      .rs_hit      (rs_hit),
      .rt_hit      (rt_hit),
      .rs_fwd_data (rs_fwd_data),
      .rt_fwd_data (rt_fwd_data),
      .count       (count)
   );

   always #5 reloj_cucu = ~reloj_cucu;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write pulse must match the oldest outstanding expectation.
   always @(negedge reloj_cucu) begin
      exp_t e;
      if (reset === 1'b0 && r_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", rd_addr, rd_w_data);
         end else begin
            e = exp_q.pop_front();
            check("drain_addr", 64'(rd_addr), 64'(e.addr));
            check("drain_data", 64'(rd_w_data), 64'(e.data));
         end
      end
   end

   task automatic push(input logic [ADDR-1:0] a, input logic [BUS_W-1:0] d);
      int tries = 0;
      @(negedge reloj_cucu);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
      while (wb_ready !== 1'b1 && tries < 20) begin
         @(negedge reloj_cucu);
         tries++;
      end
      check("push_stall_le1", 64'(tries <= 1), 64'd1);
      if (wb_ready === 1'b1) begin
         @(posedge reloj_cucu);
         if (a != 5'd0) exp_q.push_back('{addr: a, data: d});
      end
      #1 wb_valid = 1'b0;
   endtask

   task automatic check_bypass(input string name, input logic [BUS_W-1:0] d, input bit hit);
      check({name, "_hit"},  64'(rs_hit),      64'(BYP & hit));
      check({name, "_data"}, 64'(rs_fwd_data), (BYP && hit) ? 64'(d) : 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      rs_addr = '0; rt_addr = '0;
      #1;
      check("rst_r_write", 64'(r_write), 64'd0);
      check("rst_count",   64'(count),   64'd0);
      check("rst_ready",   64'(wb_ready), 64'd1);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      check("rst_rd_data", 64'(rd_w_data), 64'd0);
      @(negedge reloj_cucu);
      check("rst_ready_hold", 64'(wb_ready), 64'd1);
      reset = 1'b0;

      // Single write: queued one cycle, on the port for exactly one cycle, then held.
      push(5'd3, 32'hDEADBEEF);
      @(negedge reloj_cucu);
      check("single_queued_count", 64'(count), 64'd1);
      check("single_not_yet", 64'(r_write), 64'd0);
      @(negedge reloj_cucu);
      check("single_write", 64'(r_write), 64'd1);
      @(negedge reloj_cucu);
      check("single_one_cycle", 64'(r_write), 64'd0);
      check("single_hold_addr", 64'(rd_addr), 64'd3);
      check("single_hold_data", 64'(rd_w_data), 64'hDEADBEEF);
      check("single_count0", 64'(count), 64'd0);

      // Register 0 is accepted and dropped.
      rs_addr = 5'd0;
      push(5'd0, 32'h1234);
      @(negedge reloj_cucu);
      check("zero_count", 64'(count), 64'd0);
      check("zero_rs_hit", 64'(rs_hit), 64'd0);
      @(negedge reloj_cucu);
      check("zero_no_write", 64'(r_write), 64'd0);

      // Back-to-back stream of six writes.
      for (int i = 1; i <= 6; i++) push(ADDR'(i), 32'h100 + 32'(i));
      repeat (4) @(negedge reloj_cucu);
      check("stream_count0", 64'(count), 64'd0);

      // Bypass: single entry seen while queued and while on the write port.
      rs_addr = 5'd7; rt_addr = 5'd9;
      push(5'd7, 32'hA);
      @(negedge reloj_cucu);
      check_bypass("byp_a_queued", 32'hA, 1'b1);
      check("byp_rt_miss", 64'(rt_hit), 64'd0);
      @(negedge reloj_cucu);
      check_bypass("byp_a_port", 32'hA, 1'b1);
      @(negedge reloj_cucu);
      check_bypass("byp_a_gone", 32'h0, 1'b0);
      // Two writes to r7: the younger one wins over the one on the port.
      push(5'd7, 32'hA);
      push(5'd7, 32'hB);
      @(negedge reloj_cucu);
      check_bypass("byp_youngest", 32'hB, 1'b1);
      @(negedge reloj_cucu);
      check_bypass("byp_b_port", 32'hB, 1'b1);
      @(negedge reloj_cucu);
      check_bypass("byp_b_gone", 32'h0, 1'b0);
      rs_addr = 5'd0; rt_addr = 5'd0;

      // Reset between edges while writes are in flight.
      push(5'd10, 32'hAA10);
      push(5'd11, 32'hAA11);
      push(5'd12, 32'hAA12);
      @(negedge reloj_cucu);
      #2 reset = 1'b1;
      #1;
      check("midrst_r_write", 64'(r_write), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_ready", 64'(wb_ready), 64'd1);
      exp_q.delete();
      @(negedge reloj_cucu);
      check("midrst_ready_hold", 64'(wb_ready), 64'd1);
      reset = 1'b0;
      repeat (5) @(negedge reloj_cucu);
      check("midrst_count_after", 64'(count), 64'd0);

      // Long run to exercise pointer wrap, including every zero-address drop.
      for (int i = 0; i < 256; i++) push(ADDR'(i % 32), 32'(i));
      repeat (4) @(negedge reloj_cucu);
      check("wrap_count0", 64'(count), 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
